// File: rtl/uart_rx_stim_gen_pkg.sv
// Shared types and helpers for the UART rx stimulus generator.
// Optional parity build: define UART_STIM_PARITY_EN.
package uart_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_stim_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;

    function automatic int frame_len(int div, int data_w,
                                     int stop_bits, int par);
        int d;
        d = (div == 0) ? 1 : div;
        return (1 + data_w + stop_bits + par) * d;
    endfunction

endpackage

// File: rtl/uart_rx_stim_gen_if.sv
// Per-channel byte write handshake for the UART rx stimulus generator.
// Unaffected by UART_STIM_PARITY_EN.
interface uart_rx_stim_gen_if
    import uart_stim_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/uart_rx_stim_gen_ch.sv
// One serial channel: byte FIFO, frame FSM and bit timing.
// UART_STIM_PARITY_EN adds parity_odd and a PARITY bit after DATA.
module uart_stim_ch
    import uart_stim_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  bit_div,
`ifdef UART_STIM_PARITY_EN
    input  logic              parity_odd,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              rxd,
    output logic              busy,
    output logic              frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_W + 1);
`ifdef UART_STIM_PARITY_EN
    localparam uart_stim_state_e POST_DATA = PARITY;
`else
    localparam uart_stim_state_e POST_DATA = STOP;
`endif

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    uart_stim_state_e  state;
    logic [DIV_W-1:0]  cyc;
    logic [DIV_W-1:0]  div_q;
    logic [IW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              stop_idx;
    logic              par_q;

    logic push;
    logic wrap;
    logic last_stop;
    logic start;

    assign in_ready  = count != CW'(FIFO_DEPTH);
    assign push      = in_valid && in_ready;
    assign wrap      = cyc == div_q - 1'b1;
    assign last_stop = (state == STOP) && wrap &&
                       ((STOP_BITS == 1) || stop_idx);
    assign start     = enable && (count != '0) &&
                       ((state == IDLE) || last_stop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (start)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !start)
                count <= count + 1'b1;
            else if (!push && start)
                count <= count - 1'b1;
        end
    end

    // rxd/frame_done/busy lag the state by one cycle so every bit is
    // exactly div_q cycles wide on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cyc        <= '0;
            div_q      <= DIV_W'(1);
            bit_idx    <= '0;
            shreg      <= '0;
            stop_idx   <= 1'b0;
            par_q      <= 1'b0;
            rxd        <= UART_IDLE_LVL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rxd        <= UART_IDLE_LVL;
            frame_done <= last_stop;
            busy       <= (state != IDLE) || (count != '0);
            cyc        <= (state == IDLE || wrap) ? '0 : cyc + 1'b1;
            unique case (state)
                IDLE: ;
                START: begin
                    rxd <= 1'b0;
                    if (wrap) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    rxd <= shreg[0];
                    if (wrap) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == IW'(DATA_W - 1)) begin
                            stop_idx <= 1'b0;
                            state    <= POST_DATA;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    rxd <= par_q;
                    if (wrap)
                        state <= STOP;
                end
                STOP: begin
                    if (wrap) begin
                        stop_idx <= 1'b1;
                        if (last_stop)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (start) begin
                state <= START;
                div_q <= (bit_div == '0) ? DIV_W'(1) : bit_div;
                shreg <= mem[rd_ptr];
`ifdef UART_STIM_PARITY_EN
                par_q <= (^mem[rd_ptr]) ^ parity_odd;
`else
                par_q <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: rtl/uart_rx_stim_gen.sv
// Multi-channel UART serial-frame generator driving UART rxd lines.
// Define UART_STIM_PARITY_EN to add the parity_odd port and parity bit.
module uart_rx_stim_gen
    import uart_stim_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  bit_div,
`ifdef UART_STIM_PARITY_EN
    input  logic              parity_odd,
`endif
    uart_rx_stim_gen_if.slave bus,
    output logic [NUM_CH-1:0] rxd,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] frame_done
);
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        ready;

    assign valid        = bus.in_valid;
    assign data         = bus.in_data;
    assign bus.in_ready = ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        uart_stim_ch #(
            .DATA_W     (DATA_W),
            .DIV_W      (DIV_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .STOP_BITS  (STOP_BITS)
        ) u_ch (
            .clk        (sys_clk),
            .rst        (sys_rst),
            .enable     (enable),
            .bit_div    (bit_div),
`ifdef UART_STIM_PARITY_EN
            .parity_odd (parity_odd),
`endif
            .in_valid   (valid[c]),
            .in_data    (data[c*DATA_W +: DATA_W]),
            .in_ready   (ready[c]),
            .rxd        (rxd[c]),
            .busy       (busy[c]),
            .frame_done (frame_done[c])
        );
    end

endmodule
